// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer with imem handshake, one-word stall buffer and redirect drop.
// Define FETCH_CTRL_PERF_EN to add the fetchCount/stallCount performance counters.
module fetch_ctrl #(
  parameter logic [31:0] NOP_INST = 32'hE1A0_0000
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        stallF,
  input  logic        redirect,
  input  logic        imemAck,
  input  logic [31:0] imemRdata,
  output logic        imemReq,
  output logic        pcEnable,
  output logic        pipeEnable,
  output logic [31:0] instPipeIn,
  output logic        instValid
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0] fetchCount,
  output logic [31:0] stallCount
`endif
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_buf, w_buf;
  always_comb begin
    w_next     = r_state;
    w_buf      = r_buf;
    imemReq    = 1'b0;
    pcEnable   = 1'b0;
    pipeEnable = 1'b0;
    instPipeIn = NOP_INST;
    instValid  = 1'b0;
    case (r_state)
      IDLE: w_next = REQ;
      REQ: begin
        imemReq = 1'b1;
        if (redirect) begin
          pcEnable   = 1'b1;
          pipeEnable = 1'b1;
          w_next     = imemAck ? REQ : DROP;
        end else if (imemAck && stallF) begin
          w_buf  = imemRdata;
          w_next = HOLD;
        end else if (imemAck) begin
          pcEnable   = 1'b1;
          pipeEnable = 1'b1;
          instPipeIn = imemRdata;
          instValid  = 1'b1;
        end else
          pipeEnable = !stallF;
      end
      HOLD: begin
        if (redirect || !stallF) begin
          pcEnable   = 1'b1;
          pipeEnable = 1'b1;
          instPipeIn = redirect ? NOP_INST : r_buf;
          instValid  = !redirect;
          w_buf      = NOP_INST;
          w_next     = REQ;
        end
      end
      default: begin
        // keep the stale request up until memory acks it; PC may still move on redirect
        imemReq    = 1'b1;
        pcEnable   = redirect;
        pipeEnable = redirect || !stallF;
        w_next     = imemAck ? REQ : DROP;
      end
    endcase
  end
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_buf   <= NOP_INST;
    end else begin
      r_state <= w_next;
      r_buf   <= w_buf;
    end
  end
`ifdef FETCH_CTRL_PERF_EN
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      fetchCount <= '0;
      stallCount <= '0;
    end else begin
      fetchCount <= fetchCount + {31'd0, instValid && pipeEnable};
      stallCount <= stallCount + {31'd0, !pcEnable && r_state != IDLE};
    end
  end
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed checks of fetch_ctrl handshake, stall buffer, redirects and reset.
module tb_fetch_ctrl;
  localparam logic [31:0] N = 32'hE1A0_0000;
  typedef struct packed {
    logic [2:0]  in;
    logic [31:0] d;
    logic [3:0]  o;
    logic [31:0] inst;
  } vec_t;
  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        stallF = 1'b0, redirect = 1'b0, imemAck = 1'b0;
  logic [31:0] imemRdata = '0;
  logic        imemReq, pcEnable, pipeEnable, instValid;
  logic [31:0] instPipeIn;
  logic [31:0] tb_pc, tb_tgt = '0;
  int          total = 0, bad = 0;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] fetchCount, stallCount;
`endif
  fetch_ctrl dut (
    .clock(clock), .rst(rst), .stallF(stallF), .redirect(redirect),
    .imemAck(imemAck), .imemRdata(imemRdata), .imemReq(imemReq),
    .pcEnable(pcEnable), .pipeEnable(pipeEnable), .instPipeIn(instPipeIn),
    .instValid(instValid)
`ifdef FETCH_CTRL_PERF_EN
    , .fetchCount(fetchCount), .stallCount(stallCount)
`endif
  );
  always #5 clock = ~clock;
  always_ff @(posedge clock or posedge rst)
    if (rst) tb_pc <= '0;
    else if (pcEnable) tb_pc <= redirect ? tb_tgt : tb_pc + 32'd4;
  task automatic drive(input logic [2:0] in, input logic [31:0] d);
    @(negedge clock);
    {stallF, redirect, imemAck} = in;
    imemRdata = d;
    #1;
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clock);
    #1;
    total++;
    if ({imemReq, pcEnable, pipeEnable, instValid, instPipeIn} !== {4'b0000, N}) begin
      bad++;
      $display("FAIL reset_held got {req,pc,pipe,valid,inst}=%b %h want 0000 %h",
               {imemReq, pcEnable, pipeEnable, instValid}, instPipeIn, N);
    end
    @(negedge clock);
    rst = 1'b0;
    imemAck = 1'b1;
    imemRdata = 32'h1234_5678;
    #1;
    total++;
    if ({imemReq, pcEnable, pipeEnable, instValid, instPipeIn} !== {4'b0000, N}) begin
      bad++;
      $display("FAIL reset_idle got {req,pc,pipe,valid,inst}=%b %h want 0000 %h",
               {imemReq, pcEnable, pipeEnable, instValid}, instPipeIn, N);
    end
  endtask
  task automatic test_zero_latency();
    vec_t v [3] = '{
      '{3'b001, 32'hE3A01001, 4'b1111, 32'hE3A01001},
      '{3'b001, 32'hE2811001, 4'b1111, 32'hE2811001},
      '{3'b001, 32'hE3A01001, 4'b1111, 32'hE3A01001}};
    foreach (v[i]) begin
      drive(v[i].in, v[i].d);
      total++;
      if ({imemReq, pcEnable, pipeEnable, instValid, instPipeIn} !== {v[i].o, v[i].inst}) begin
        bad++;
        $display("FAIL zero_latency cycle %0d got {req,pc,pipe,valid,inst}=%b %h want %b %h",
                 i, {imemReq, pcEnable, pipeEnable, instValid}, instPipeIn, v[i].o, v[i].inst);
      end
    end
  endtask
  task automatic test_latency3();
    vec_t v [6] = '{
      '{3'b000, 32'h0, 4'b1010, N},
      '{3'b000, 32'h0, 4'b1010, N},
      '{3'b001, 32'hE0800001, 4'b1111, 32'hE0800001},
      '{3'b000, 32'h0, 4'b1010, N},
      '{3'b000, 32'h0, 4'b1010, N},
      '{3'b001, 32'hE0800002, 4'b1111, 32'hE0800002}};
    foreach (v[i]) begin
      drive(v[i].in, v[i].d);
      total++;
      if ({imemReq, pcEnable, pipeEnable, instValid, instPipeIn} !== {v[i].o, v[i].inst}) begin
        bad++;
        $display("FAIL latency3 cycle %0d got {req,pc,pipe,valid,inst}=%b %h want %b %h",
                 i, {imemReq, pcEnable, pipeEnable, instValid}, instPipeIn, v[i].o, v[i].inst);
      end
    end
  endtask
  task automatic test_stall_hold();
    vec_t v [7] = '{
      '{3'b100, 32'h0, 4'b1000, N},
      '{3'b101, 32'hE0812003, 4'b1000, N},
      '{3'b100, 32'h0, 4'b0000, N},
      '{3'b101, 32'hBADC0DE5, 4'b0000, N},
      '{3'b100, 32'h0, 4'b0000, N},
      '{3'b000, 32'h0, 4'b0111, 32'hE0812003},
      '{3'b001, 32'hE3A03003, 4'b1111, 32'hE3A03003}};
    foreach (v[i]) begin
      drive(v[i].in, v[i].d);
      total++;
      if ({imemReq, pcEnable, pipeEnable, instValid, instPipeIn} !== {v[i].o, v[i].inst}) begin
        bad++;
        $display("FAIL stall_hold cycle %0d got {req,pc,pipe,valid,inst}=%b %h want %b %h",
                 i, {imemReq, pcEnable, pipeEnable, instValid}, instPipeIn, v[i].o, v[i].inst);
      end
    end
  endtask
  task automatic test_redirect_drop();
    vec_t v [6] = '{
      '{3'b000, 32'h0, 4'b1010, N},
      '{3'b010, 32'h0, 4'b1110, N},
      '{3'b100, 32'h0, 4'b1000, N},
      '{3'b010, 32'h0, 4'b1110, N},
      '{3'b001, 32'hDEADBEEF, 4'b1010, N},
      '{3'b001, 32'hE3A02005, 4'b1111, 32'hE3A02005}};
    tb_tgt = 32'h100;
    foreach (v[i]) begin
      drive(v[i].in, v[i].d);
      total++;
      if ({imemReq, pcEnable, pipeEnable, instValid, instPipeIn} !== {v[i].o, v[i].inst}) begin
        bad++;
        $display("FAIL redirect_drop cycle %0d got {req,pc,pipe,valid,inst}=%b %h want %b %h",
                 i, {imemReq, pcEnable, pipeEnable, instValid}, instPipeIn, v[i].o, v[i].inst);
      end
    end
    total++;
    if (tb_pc !== 32'h100) begin
      bad++;
      $display("FAIL redirect_drop_pc got pc=%h want %h", tb_pc, 32'h100);
    end
  endtask
  task automatic test_redirect_ack();
    vec_t v [2] = '{
      '{3'b011, 32'hCAFEF00D, 4'b1110, N},
      '{3'b001, 32'hE3A04004, 4'b1111, 32'hE3A04004}};
    tb_tgt = 32'h180;
    foreach (v[i]) begin
      drive(v[i].in, v[i].d);
      total++;
      if ({imemReq, pcEnable, pipeEnable, instValid, instPipeIn} !== {v[i].o, v[i].inst}) begin
        bad++;
        $display("FAIL redirect_ack cycle %0d got {req,pc,pipe,valid,inst}=%b %h want %b %h",
                 i, {imemReq, pcEnable, pipeEnable, instValid}, instPipeIn, v[i].o, v[i].inst);
      end
    end
    total++;
    if (tb_pc !== 32'h180) begin
      bad++;
      $display("FAIL redirect_ack_pc got pc=%h want %h", tb_pc, 32'h180);
    end
  endtask
  task automatic test_redirect_hold();
    vec_t v [4] = '{
      '{3'b101, 32'hE1A01002, 4'b1000, N},
      '{3'b100, 32'h0, 4'b0000, N},
      '{3'b110, 32'h0, 4'b0110, N},
      '{3'b001, 32'hE2822001, 4'b1111, 32'hE2822001}};
    tb_tgt = 32'h300;
    foreach (v[i]) begin
      drive(v[i].in, v[i].d);
      total++;
      if ({imemReq, pcEnable, pipeEnable, instValid, instPipeIn} !== {v[i].o, v[i].inst}) begin
        bad++;
        $display("FAIL redirect_hold cycle %0d got {req,pc,pipe,valid,inst}=%b %h want %b %h",
                 i, {imemReq, pcEnable, pipeEnable, instValid}, instPipeIn, v[i].o, v[i].inst);
      end
    end
    total++;
    if (tb_pc !== 32'h300) begin
      bad++;
      $display("FAIL redirect_hold_pc got pc=%h want %h", tb_pc, 32'h300);
    end
  endtask
  task automatic test_reset_mid();
    drive(3'b000, 32'h0);
    @(negedge clock);
    rst = 1'b1;
    imemAck = 1'b1;
    imemRdata = 32'hE3A05005;
    #1;
    total++;
    if ({imemReq, pcEnable, pipeEnable, instValid, instPipeIn} !== {4'b0000, N}) begin
      bad++;
      $display("FAIL reset_mid got {req,pc,pipe,valid,inst}=%b %h want 0000 %h",
               {imemReq, pcEnable, pipeEnable, instValid}, instPipeIn, N);
    end
    @(negedge clock);
    rst = 1'b0;
    #1;
    total++;
    if ({imemReq, pcEnable, pipeEnable, instValid} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_mid_idle got {req,pc,pipe,valid}=%b want 0000",
               {imemReq, pcEnable, pipeEnable, instValid});
    end
    drive(3'b000, 32'h0);
    total++;
    if ({imemReq, pcEnable, pipeEnable, instValid, instPipeIn} !== {4'b1010, N}) begin
      bad++;
      $display("FAIL reset_mid_req got {req,pc,pipe,valid,inst}=%b %h want 1010 %h",
               {imemReq, pcEnable, pipeEnable, instValid}, instPipeIn, N);
    end
  endtask
`ifdef FETCH_CTRL_PERF_EN
  task automatic test_perf();
    @(negedge clock);
    rst = 1'b1;
    @(negedge clock);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) drive(3'b001, 32'hE3A00000 + i);
    for (int i = 0; i < 6; i++) drive(3'b000, 32'h0);
    drive(3'b000, 32'h0);
    total++;
    if ({fetchCount, stallCount} !== {32'd10, 32'd6}) begin
      bad++;
      $display("FAIL perf_counts got fetch=%0d stall=%0d want 10 6", fetchCount, stallCount);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({fetchCount, stallCount} !== 64'd0) begin
      bad++;
      $display("FAIL perf_reset got fetch=%0d stall=%0d want 0 0", fetchCount, stallCount);
    end
    @(negedge clock);
    rst = 1'b0;
  endtask
`endif
  initial begin
    test_reset();
    test_zero_latency();
    test_latency3();
    test_stall_hold();
    test_redirect_drop();
    test_redirect_ack();
    test_redirect_hold();
    test_reset_mid();
`ifdef FETCH_CTRL_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-stage sequencer for the pipelined ARM core. It drives the PC register enable and the fetch/decode pipe-register enable, and runs a request/acknowledge handshake with a variable-latency instruction memory. It buffers one returned instruction while decode is stalled, and discards in-flight fetches when the PC is redirected by a branch or a PC write in writeback. It sits between the fetch datapath, the hazard unit and the instruction memory port.

## Interface
Parameters:
- NOP_INST, 32'hE1A0_0000, bubble word (MOV r0,r0) injected into decode when no valid instruction is available

Ports:
- clock  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- stallF  in  1  hazard unit: hold fetch and decode
- redirect  in  1  PC redirect this cycle (pcSrcW or taken Branch); fetch datapath selects the target
- imemAck  in  1  instruction memory: data valid, single-cycle pulse
- imemRdata  in  32  instruction word, valid when imemAck=1
- imemReq  out  1  request to instruction memory, address = current PC
- pcEnable  out  1  PC register load enable
- pipeEnable  out  1  fetch/decode pipe register enable
- instPipeIn  out  32  word presented to the fetch/decode pipe register
- instValid  out  1  instPipeIn is a real instruction, not a bubble
- fetchCount, stallCount  out  32 each  present only with FETCH_CTRL_PERF_EN

## Operation
States: IDLE, REQ, HOLD, DROP. Priority for all decisions: rst, then redirect, then stallF.

Memory protocol:
- A request is issued in the first cycle imemReq=1 with nothing outstanding. Memory latches the PC in that cycle.
- imemReq stays high until the imemAck cycle.
- Data is valid in the ack cycle. Latency is 1..N cycles.

State behaviour:
- IDLE: entered on reset. All enables are 0. Moves to REQ after one cycle. imemAck is ignored.
- REQ: imemReq=1.
  - ack, no stall, no redirect: pcEnable=1, pipeEnable=1, instPipeIn=imemRdata, instValid=1. Stay in REQ; the next request is issued with the new PC.
  - ack with stallF: capture imemRdata in the buffer. pcEnable=0, pipeEnable=0. Go to HOLD.
  - ack with redirect: discard the data. pcEnable=1, pipeEnable=1 with NOP_INST, instValid=0. Stay in REQ.
  - no ack, no redirect: pcEnable=0, pipeEnable=!stallF with NOP_INST, instValid=0.
  - no ack with redirect: pcEnable=1 for one cycle, pipeEnable=1 with NOP. Go to DROP.
- HOLD: imemReq=0, enables 0.
  - stallF falls: pipeEnable=1, instPipeIn=buffer, instValid=1, pcEnable=1. Go to REQ.
  - redirect: discard the buffer. pcEnable=1, pipeEnable=1 with NOP. Go to REQ.
- DROP: imemReq=1 to complete the stale transaction. pcEnable=0. pipeEnable=!stallF with NOP.
  - ack: discard the data. Go to REQ.
  - A further redirect in DROP: pcEnable=1 again. Stay in DROP.

## Timing
- Reset values: imemReq=0, pcEnable=0, pipeEnable=0, instPipeIn=NOP_INST, instValid=0, buffer=NOP_INST, counters=0, state IDLE.
- First imemReq is the second rising edge after rst deasserts.
- Zero-wait memory (ack in the issue cycle) gives one instruction per cycle.
- Ack-to-decode latency is 0 cycles combinational into the pipe register, captured at the next edge.
- Outputs are registered state plus combinational decode of imemAck, stallF and redirect in the current cycle.
- Reset mid-transaction returns to IDLE. Any ack arriving in IDLE or HOLD is ignored.
- Counters wrap modulo 2^32.

## Configuration
- FETCH_CTRL_PERF_EN defined:
  - fetchCount increments on every cycle with instValid=1 and pipeEnable=1.
  - stallCount increments on every cycle with pcEnable=0 outside IDLE.
- FETCH_CTRL_PERF_EN undefined: both ports and counters are absent. Behaviour is otherwise identical.

## Test plan
- Reset, zero-latency memory returning 0xE3A01001, 0xE2811001 → IDLE 1 cycle, then pcEnable=pipeEnable=instValid=1 every cycle, instPipeIn matches the data in order.
- 3-cycle latency → two bubble cycles with instPipeIn=0xE1A00000, instValid=0, pcEnable=0, then one valid word; repeats.
- stallF high in the ack cycle with data 0xE0812003, held 4 cycles → HOLD, enables 0, imemReq=0. Release gives instPipeIn=0xE0812003 with pcEnable=1 in the same cycle.
- redirect one cycle after issue with 3-cycle latency → single pcEnable pulse, DROP. Stale ack data is never marked valid. The next request uses the target PC.
- redirect while in HOLD → buffer discarded, NOP with instValid=0, next fetch from target.
- With FETCH_CTRL_PERF_EN: 10 valid fetches and 6 stall cycles → fetchCount=10, stallCount=6. rst mid-run → both 0.
